// File: rtl/register_file.sv
// 16 x 16-bit CPU register file: one shared address, registered read port,
// write-through echo on o_data, entry 0 hardwired to zero.
module register_file #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rw,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    logic              addr_is_zero;
    logic              wr_en;
    logic [DEPTH-1:0]  wr_sel;

    assign addr_is_zero = (i_addr == '0);
    assign wr_en        = i_rw && !addr_is_zero;

    // One-hot write decode; bit 0 can never be set, so entry 0 is never loaded.
    always_comb begin
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[i_addr] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_sel[i]) begin
                regs_d[i] = i_data;
            end
        end
        regs_d[0] = '0;
    end

    // A write echoes its own data, so a following read of the same entry
    // and the echo agree without any bypass path.
    always_comb begin
        rdata_d = '0;
        if (i_rw) begin
            rdata_d = wr_en ? i_data : '0;
        end else if (!addr_is_zero) begin
            rdata_d = regs_q[i_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_q <= rdata_d;
        end
    end

    assign o_data = rdata_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, hold/latency sequence,
// then randomized traffic against a behavioural model.
module tb_register_file;

    typedef struct {
        logic        rst_n;
        logic        rw;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr;
    logic        rw;
    logic [15:0] wdata;
    logic [15:0] rdata;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [16];
    vec_t        vecs [$];

    register_file #(.DATA_W(16), .ADDR_W(4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_addr (addr),
        .i_rw   (rw),
        .i_data (wdata),
        .o_data (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one operation, let one rising edge consume it, return 1ns later.
    task automatic apply(input logic r, input logic w, input logic [3:0] a, input logic [15:0] d);
        rst_n = r;
        rw    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_step(input logic r, input logic w,
                                               input logic [3:0] a, input logic [15:0] d);
        logic [15:0] res;
        if (!r) begin
            for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
            res = 16'h0000;
        end else if (w) begin
            if (a != 0) model_mem[a] = d;
            res = (a == 0) ? 16'h0000 : d;
        end else begin
            res = (a == 0) ? 16'h0000 : model_mem[a];
        end
        return res;
    endfunction

    task automatic add(input logic r, input logic w, input logic [3:0] a,
                       input logic [15:0] d, input logic [15:0] e, input string n);
        vec_t v;
        v.rst_n = r; v.rw = w; v.addr = a; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        rw    = 1'b0;
        addr  = 4'd0;
        wdata = 16'h0000;

        // Expected values below are written out by hand.
        add(0, 0, 4'd0, 16'h0000, 16'h0000, "reset_edge0");
        add(0, 0, 4'd0, 16'h0000, 16'h0000, "reset_edge1");
        for (int n = 0; n < 16; n++) add(1, 0, 4'(n), 16'h0000, 16'h0000, $sformatf("post_reset_rd%0d", n));
        add(1, 1, 4'd3, 16'hA5A5, 16'hA5A5, "wr3_echo");
        add(1, 0, 4'd3, 16'h0000, 16'hA5A5, "rd3_back");
        for (int n = 1; n < 16; n++) add(1, 1, 4'(n), 16'(16'h1000 + n), 16'(16'h1000 + n), $sformatf("wr_all_echo%0d", n));
        for (int n = 0; n < 16; n++) add(1, 0, 4'(n), 16'hDEAD, (n == 0) ? 16'h0000 : 16'(16'h1000 + n), $sformatf("rd_all%0d", n));
        add(1, 1, 4'd0, 16'hFFFF, 16'h0000, "wr0_echo");
        add(1, 0, 4'd0, 16'hFFFF, 16'h0000, "rd0");
        add(1, 1, 4'd5, 16'h5555, 16'h5555, "wr5_pre");
        add(0, 1, 4'd5, 16'h1234, 16'h0000, "rst_with_wr5");
        add(1, 0, 4'd5, 16'h0000, 16'h0000, "rd5_after_rst");
        add(1, 0, 4'd3, 16'h0000, 16'h0000, "rd3_after_rst");
        add(1, 1, 4'd9, 16'h9999, 16'h9999, "wr9");
        add(1, 0, 4'd9, 16'h0000, 16'h9999, "rd9");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst_n, vecs[i].rw, vecs[i].addr, vecs[i].data);
            check(vecs[i].name, rdata, vecs[i].exp);
        end

        // Read latency and hold: o_data must ignore mid-cycle input changes.
        apply(1, 1, 4'd7, 16'h0077);
        apply(1, 1, 4'd8, 16'h0088);
        apply(1, 0, 4'd7, 16'h0000);
        check("hold_rd7", rdata, 16'h0077);
        #3;
        addr  = 4'd8;
        wdata = 16'hBEEF;
        #3;
        check("hold_mid_cycle", rdata, 16'h0077);
        rw = 1'b1;
        #1;
        check("hold_rw_flip", rdata, 16'h0077);
        rw = 1'b0;
        @(posedge clk);
        #1;
        check("hold_next_edge_rd8", rdata, 16'h0088);

        // Randomized traffic against the model, starting from a reset.
        void'(model_step(1'b0, 1'b0, 4'd0, 16'h0000));
        apply(0, 0, 4'd0, 16'h0000);
        check("rand_reset", rdata, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        w;
            logic [3:0]  a;
            logic [15:0] d;
            logic [15:0] e;
            r = ($urandom_range(0, 39) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            e = model_step(r, w, a, d);
            apply(r, w, a, d);
            check($sformatf("rand%0d_%s_a%0d", i, w ? "wr" : "rd", a), rdata, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
